// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS front end:
//   - primary opcode constants (instr[31:26]) consumed by the control decoder
//   - fetch FSM state encoding
//   - default reset PC and fetch timeout
//   - word_align() helper used to form word addresses
// ---------------------------------------------------------------------------
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // Fetch FSM: FETCH requests a word, VALID presents it until consumed
    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [7:0]  DEFAULT_TIMEOUT  = 8'd255;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Combinational next-PC selection for the instruction being consumed.
// Ports:
//   i_pcPlus4  in  32  address of current instruction + 4
//   i_instr    in  32  current instruction word
//   i_branch   in  1   decoder: instruction is BEQ
//   i_jump     in  1   decoder: instruction is J
//   i_zero     in  1   ALU zero flag for the instruction
//   o_nextPc   out 32  selected next PC
// ---------------------------------------------------------------------------
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] i_pcPlus4,
    input  logic [31:0] i_instr,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_zero,
    output logic [31:0] o_nextPc
);

    logic [31:0] w_jumpTarget;
    logic [31:0] w_branchOffset;
    logic [31:0] w_branchTarget;

    // J keeps the 256 MB region of the delay-slot address
    assign w_jumpTarget   = {i_pcPlus4[31:28], i_instr[25:0], 2'b00};

    // Sign-extended word offset, scaled to bytes
    assign w_branchOffset = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};

    // Plain 32-bit add: wraps modulo 2^32
    assign w_branchTarget = i_pcPlus4 + w_branchOffset;

    // Jump takes priority over a taken branch
    always_comb begin
        o_nextPc = i_pcPlus4;
        if (i_jump) begin
            o_nextPc = w_jumpTarget;
        end else if (i_branch && i_zero) begin
            o_nextPc = w_branchTarget;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Instruction-fetch stage: holds the PC, fetches one 32-bit word at a time
// over a req/ready handshake, presents it to decode until consumed, then
// advances the PC using the decoder's branch/jump and the ALU zero flag.
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   TIMEOUT    wait cycles tolerated before fetchErr sets
// Ports:
//   clk         in   1   clock
//   rstN        in   1   synchronous active-low reset
//   imemReq     out  1   fetch request
//   imemAddr    out  32  word-aligned fetch address
//   imemReady   in   1   memory returns imemData this cycle
//   imemData    in   32  instruction word
//   instr       out  32  fetched instruction
//   instrValid  out  1   instr is valid and not yet consumed
//   pcPlus4     out  32  address of instr + 4
//   stall       in   1   downstream cannot consume this cycle
//   branch      in   1   decoder: BEQ
//   jump        in   1   decoder: J
//   zero        in   1   ALU zero flag
//   fetchErr    out  1   sticky fetch-timeout flag
//   instrCount  out  32  instructions consumed since reset
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [7:0]  TIMEOUT  = DEFAULT_TIMEOUT
)
(
    input  logic        clk,
    input  logic        rstN,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] pcPlus4,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic        fetchErr,
    output logic [31:0] instrCount
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_instrValid;
    logic [7:0]   r_waitCnt;
    logic [31:0]  r_instrCount;
    logic         r_fetchErr;

    logic [31:0]  w_pcPlus4;
    logic [31:0]  w_nextPc;

    assign w_pcPlus4 = r_pc + 32'd4;

    next_pc_calc u_next_pc_calc (
        .i_pcPlus4 (w_pcPlus4),
        .i_instr   (r_instr),
        .i_branch  (branch),
        .i_jump    (jump),
        .i_zero    (zero),
        .o_nextPc  (w_nextPc)
    );

    // The reset state is FETCH, so the request must also be masked while
    // rstN is low; otherwise memory would see a request during reset.
    assign imemReq    = (r_state == FETCH) && rstN;
    assign imemAddr   = word_align(r_pc);
    assign pcPlus4    = w_pcPlus4;
    assign instr      = r_instr;
    assign instrValid = r_instrValid;
    assign fetchErr   = r_fetchErr;
    assign instrCount = r_instrCount;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_instr      <= 32'd0;
            r_instrValid <= 1'b0;
            r_waitCnt    <= 8'd0;
            r_instrCount <= 32'd0;
            r_fetchErr   <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imemReady) begin
                        r_instr      <= imemData;
                        r_instrValid <= 1'b1;
                        r_waitCnt    <= 8'd0;
                        r_state      <= VALID;
                    end else begin
                        // Counter saturates; the request is never withdrawn,
                        // the timeout only raises the sticky error flag.
                        if (r_waitCnt != TIMEOUT) begin
                            r_waitCnt <= r_waitCnt + 8'd1;
                        end
                        if (r_waitCnt == TIMEOUT) begin
                            r_fetchErr <= 1'b1;
                        end
                    end
                end
                VALID: begin
                    // branch/jump/zero only matter on the consuming cycle
                    if (!stall) begin
                        r_instrValid <= 1'b0;
                        r_instrCount <= r_instrCount + 32'd1;
                        r_pc         <= w_nextPc;
                        r_state      <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pcPlus4;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        zero;
    logic        fetchErr;
    logic [31:0] instrCount;

    int tests  = 0;
    int failed = 0;

    // Reference state: expected PC of the next fetch, consumed count, error flag
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_err;

    localparam logic [31:0] ADDI_W  = 32'h2008_0005;
    localparam logic [31:0] BEQ_M4  = 32'h1022_FFFC;   // BEQ imm = -4
    localparam logic [31:0] BEQ_M2  = 32'h1022_FFFE;   // BEQ imm = -2
    localparam logic [31:0] J_100   = 32'h0800_0040;   // J addr26 = 0x40
    localparam logic [31:0] J_40    = 32'h0800_0010;   // J addr26 = 0x10

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (8'd255)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemData   (imemData),
        .instr      (instr),
        .instrValid (instrValid),
        .pcPlus4    (pcPlus4),
        .stall      (stall),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .fetchErr   (fetchErr),
        .instrCount (instrCount)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, written with signed arithmetic
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic br, input logic j, input logic z);
        logic [31:0] p4;
        int          imm;
        p4  = pc + 32'd4;
        imm = int'($signed(w[15:0]));
        if (j)
            return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
        else if (br && z)
            return p4 + 32'(imm * 4);
        else
            return p4;
    endfunction

    // One full instruction: fetch (optionally delayed), optional stall, consume
    task automatic do_instr(input logic [31:0] data, input int rdly, input int nstall,
                            input logic br, input logic j, input logic z);
        check("req_at_fetch", {31'd0, imemReq}, 32'd1);
        check("fetch_addr", imemAddr, m_pc);
        check("valid_at_fetch", {31'd0, instrValid}, 32'd0);
        for (int k = 0; k < rdly; k++) begin
            imemReady = 1'b0;
            imemData  = $urandom;
            tick();
            check("req_while_wait", {31'd0, imemReq}, 32'd1);
            check("addr_while_wait", imemAddr, m_pc);
        end
        if (rdly >= 260) m_err = 1'b1;
        check("fetchErr_after_wait", {31'd0, fetchErr}, {31'd0, m_err});
        imemReady = 1'b1;
        imemData  = data;
        tick();
        imemReady = 1'b0;
        imemData  = $urandom;
        check("valid_after_ready", {31'd0, instrValid}, 32'd1);
        check("instr_captured", instr, data);
        check("pcPlus4", pcPlus4, m_pc + 32'd4);
        check("req_in_valid", {31'd0, imemReq}, 32'd0);
        for (int k = 0; k < nstall; k++) begin
            stall     = 1'b1;
            imemReady = 1'($urandom_range(0, 1));
            branch    = 1'($urandom_range(0, 1));
            jump      = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            tick();
            check("stall_instr", instr, data);
            check("stall_valid", {31'd0, instrValid}, 32'd1);
            check("stall_req", {31'd0, imemReq}, 32'd0);
            check("stall_pc", pcPlus4, m_pc + 32'd4);
            check("stall_count", instrCount, m_count);
        end
        imemReady = 1'b0;
        stall     = 1'b0;
        branch    = br;
        jump      = j;
        zero      = z;
        tick();
        branch = 1'b0;
        jump   = 1'b0;
        zero   = 1'b0;
        m_pc    = ref_next(m_pc, data, br, j, z);
        m_count = m_count + 32'd1;
        check("valid_after_consume", {31'd0, instrValid}, 32'd0);
        check("count_after_consume", instrCount, m_count);
        check("next_addr", imemAddr, m_pc);
        check("fetchErr_sticky", {31'd0, fetchErr}, {31'd0, m_err});
        $display("[TB] instr %h consumed, next fetch %h, count %0d", data, imemAddr, instrCount);
    endtask

    initial begin
        rstN      = 1'b0;
        imemReady = 1'b1;
        imemData  = 32'hDEAD_BEEF;
        stall     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        zero      = 1'b0;
        repeat (3) tick();
        check("reset_req", {31'd0, imemReq}, 32'd0);
        check("reset_valid", {31'd0, instrValid}, 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_count", instrCount, 32'd0);
        check("reset_err", {31'd0, fetchErr}, 32'd0);
        rstN  = 1'b1;
        m_pc    = 32'd0;
        m_count = 32'd0;
        m_err   = 1'b0;
        #1;

        // Sequential ADDIs: 0,4,8 then 0xC
        for (int i = 0; i < 3; i++) do_instr(ADDI_W, 0, 0, 1'b0, 1'b0, 1'b0);
        check("count_after_3", instrCount, 32'd3);
        do_instr(ADDI_W, 0, 0, 1'b0, 1'b0, 1'b0);

        // BEQ at 0x10, taken -> 0x04
        do_instr(BEQ_M4, 0, 0, 1'b1, 1'b0, 1'b1);
        check("beq_taken_addr", imemAddr, 32'h0000_0004);
        for (int i = 0; i < 3; i++) do_instr(ADDI_W, 0, 0, 1'b0, 1'b0, 1'b0);
        // BEQ at 0x10, not taken -> 0x14
        do_instr(BEQ_M4, 0, 0, 1'b1, 1'b0, 1'b0);
        check("beq_not_taken_addr", imemAddr, 32'h0000_0014);
        for (int i = 0; i < 3; i++) do_instr(ADDI_W, 0, 0, 1'b0, 1'b0, 1'b0);

        // J at 0x20 with branch also asserted: jump wins -> 0x100
        do_instr(J_100, 0, 0, 1'b1, 1'b1, 1'b1);
        check("jump_addr", imemAddr, 32'h0000_0100);

        // Stall five cycles in VALID
        do_instr(ADDI_W, 0, 5, 1'b0, 1'b0, 1'b0);
        check("after_stall_addr", imemAddr, 32'h0000_0104);

        // Long waits: below and well beyond the timeout
        do_instr(ADDI_W, 250, 0, 1'b0, 1'b0, 1'b0);
        check("no_err_250", {31'd0, fetchErr}, 32'd0);
        do_instr(ADDI_W, 300, 0, 1'b0, 1'b0, 1'b0);
        check("err_after_300", {31'd0, fetchErr}, 32'd1);

        // Jump to 0x40, then reset in the middle of a waiting fetch
        do_instr(J_40, 0, 0, 1'b0, 1'b1, 1'b0);
        check("addr_0x40", imemAddr, 32'h0000_0040);
        imemReady = 1'b0;
        repeat (3) tick();
        rstN      = 1'b0;
        imemReady = 1'b1;
        tick();
        check("midreset_req", {31'd0, imemReq}, 32'd0);
        check("midreset_valid", {31'd0, instrValid}, 32'd0);
        check("midreset_err", {31'd0, fetchErr}, 32'd0);
        check("midreset_count", instrCount, 32'd0);
        imemReady = 1'b0;
        rstN      = 1'b1;
        #1;
        m_pc    = 32'd0;
        m_count = 32'd0;
        m_err   = 1'b0;
        check("post_reset_addr", imemAddr, 32'd0);

        // Address wrap: branch back from 0 to 0xFFFF_FFFC, then +4 wraps to 0
        do_instr(BEQ_M2, 0, 0, 1'b1, 1'b0, 1'b1);
        check("wrap_top_addr", imemAddr, 32'hFFFF_FFFC);
        check("wrap_pcPlus4", pcPlus4, 32'd0);
        do_instr(ADDI_W, 0, 0, 1'b0, 1'b0, 1'b0);
        check("wrap_zero_addr", imemAddr, 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            do_instr($urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
